// File: rtl/gate_arb_pkg.sv
// Shared constants for the gate_op_arbiter slice: opcodes, FSM encoding, stats counter width.
package gate_arb_pkg;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam int OPCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/gate_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping modulo N_REQ.
module gate_arb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    index
);
    int   w_idx;
    logic w_found;

    always_comb begin
        onehot  = '0;
        index   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(rr_ptr) + k;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            if (!w_found && req[w_idx]) begin
                w_found       = 1'b1;
                onehot[w_idx] = 1'b1;
                index         = w_idx[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin sequencer sharing one registered AND/OR/XOR/NAND unit among N_REQ requesters.
// Define GATE_ARB_STATS_EN to add the saturating op_count port.
module gate_op_arbiter
    import gate_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] a_in,
    input  logic [WIDTH*N_REQ-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_y,
    output logic                   busy
`ifdef GATE_ARB_STATS_EN
    ,
    output logic [OPCNT_W-1:0]     op_count
`endif
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           r_state;
    logic [PW-1:0]    r_rr_ptr;
    logic [PW-1:0]    r_win;
    logic [1:0]       r_op_l;
    logic [WIDTH-1:0] r_a_l;
    logic [WIDTH-1:0] r_b_l;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_y;
    logic             r_busy;

    logic [N_REQ-1:0] w_pick_oh;
    logic [PW-1:0]    w_pick_idx;
    logic [WIDTH-1:0] w_y;

    gate_arb_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .onehot (w_pick_oh),
        .index  (w_pick_idx)
    );

    always_comb begin
        w_y = '0;
        case (r_op_l)
            OP_AND:  w_y = r_a_l & r_b_l;
            OP_OR:   w_y = r_a_l | r_b_l;
            OP_XOR:  w_y = r_a_l ^ r_b_l;
            OP_NAND: w_y = ~(r_a_l & r_b_l);
            default: w_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_win       <= '0;
            r_op_l      <= '0;
            r_a_l       <= '0;
            r_b_l       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_y     <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req != '0) begin
                    // Operands are captured here so later input changes cannot disturb the result.
                    r_win   <= w_pick_idx;
                    r_op_l  <= op[2*w_pick_idx +: 2];
                    r_a_l   <= a_in[WIDTH*w_pick_idx +: WIDTH];
                    r_b_l   <= b_in[WIDTH*w_pick_idx +: WIDTH];
                    r_gnt   <= w_pick_oh;
                    r_busy  <= 1'b1;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_rsp_y     <= w_y;
                    r_rsp_valid <= r_gnt;
                    r_state     <= DONE;
                end
                DONE: begin
                    r_rsp_valid <= '0;
                    r_gnt       <= '0;
                    r_busy      <= 1'b0;
                    r_rr_ptr    <= (r_win == PW'(N_REQ-1)) ? '0 : r_win + 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign busy      = r_busy;

`ifdef GATE_ARB_STATS_EN
    logic [OPCNT_W-1:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_op_count <= '0;
        else if (r_state == DONE && r_op_count != '1)
            r_op_count <= r_op_count + 1'b1;
    end

    assign op_count = r_op_count;
`endif
endmodule

// File: tb/tb_gate_op_arbiter.sv
// Randomized self-checking bench for gate_op_arbiter against a transaction-level round-robin model.
module tb_gate_op_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_y;
    logic        busy;
`ifdef GATE_ARB_STATS_EN
    logic [15:0] op_count;
`endif

    int n_chk  = 0;
    int n_err  = 0;
    int ptr    = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    gate_op_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .busy      (busy)
`ifdef GATE_ARB_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic int ref_pick(input logic [3:0] rq, input int p);
        for (int k = 0; k < 4; k++)
            if (rq[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Called at a negedge with the DUT idle; one full 3-cycle transaction.
    task automatic run_txn(input logic [3:0] rq, input bit scramble);
        int w;
        logic [7:0] exp_y;
        logic [3:0] oh;
        w = ref_pick(rq, ptr);
        if (w < 0) begin
            chk("bench_req_nonzero", 32'(rq), 32'hF);
            return;
        end
        exp_y = ref_op(op[2*w +: 2], a_in[8*w +: 8], b_in[8*w +: 8]);
        oh = 4'(1 << w);
        req = rq;
        @(posedge clk); @(negedge clk);
        chk("gnt_t1", 32'(gnt), 32'(oh));
        chk("busy_t1", 32'(busy), 32'd1);
        chk("rsp_valid_t1", 32'(rsp_valid), 32'd0);
        if (scramble) begin
            req  = 4'($urandom);
            op   = 8'($urandom);
            a_in = $urandom;
            b_in = $urandom;
        end
        @(posedge clk); @(negedge clk);
        chk("rsp_valid_t2", 32'(rsp_valid), 32'(oh));
        chk("rsp_y_t2", 32'(rsp_y), 32'(exp_y));
        chk("gnt_t2", 32'(gnt), 32'(oh));
        chk("busy_t2", 32'(busy), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("busy_t3", 32'(busy), 32'd0);
        chk("gnt_t3", 32'(gnt), 32'd0);
        chk("rsp_valid_t3", 32'(rsp_valid), 32'd0);
        ptr = (w + 1) % 4;
        n_done++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        ptr    = 0;
        n_done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; op = '0; a_in = '0; b_in = '0;
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_y", 32'(rsp_y), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Single requester 1, AND F0 & 3C.
        op[3:2] = 2'd0; a_in[15:8] = 8'hF0; b_in[15:8] = 8'h3C;
        run_txn(4'b0010, 1'b0);

        // Opcode sweep on requester 0.
        a_in[7:0] = 8'hAA; b_in[7:0] = 8'h0F;
        for (int o = 0; o < 4; o++) begin
            op[1:0] = 2'(o);
            run_txn(4'b0001, 1'b0);
        end

        // All four requesting continuously from reset.
        do_reset();
        op = 8'($urandom); a_in = $urandom; b_in = $urandom;
        for (int i = 0; i < 5; i++) run_txn(4'hF, 1'b0);

        // Inputs changed and req dropped after grant.
        for (int i = 0; i < 4; i++) begin
            op = 8'($urandom); a_in = $urandom; b_in = $urandom;
            run_txn(4'($urandom_range(1, 15)), 1'b1);
        end

        // Reset during EXEC aborts and returns pointer to 0.
        run_txn(4'b0010, 1'b0);
        req = 4'b1000;
        @(posedge clk); @(negedge clk);
        chk("abort_gnt_pre", 32'(gnt), 32'h8);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; req = '0;
        ptr = 0; n_done = 0;
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        run_txn(4'b1001, 1'b0);
        run_txn(4'b1000, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            op = 8'($urandom); a_in = $urandom; b_in = $urandom;
            run_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                @(posedge clk); @(negedge clk);
                chk("idle_gap_busy", 32'(busy), 32'd0);
            end
        end

`ifdef GATE_ARB_STATS_EN
        chk("op_count", 32'(op_count), 32'(n_done));
`endif
        req = '0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
